// File: rtl/fconvi_mod.sv
// fconvi_mod: floating-point to 64-bit integer converter (three-stage pipeline).
//
// Converts one single, double or extended operand per advancing cycle into a
// 65-bit integer (bit 64 is a sign copy for signed results, 0 for unsigned).
// Truncates toward zero and saturates on overflow. The operand type encoding
// used on typ is 0 = single, 1 = double, 2 = extended; 3 is undefined and
// produces res 0 with no flags.
//
// Ports:
//   clk    clock
//   rst    asynchronous active-low reset
//   en     operand valid this cycle
//   clkEn  pipeline advance; 0 holds every stage and output
//   A      unpacked operand (single A[31:0], double A[63:0], extended A[79:0])
//   typ    operand type
//   isS    1 = signed int64 result, 0 = unsigned uint64 result
//   res    integer result
//   rdy    res/flg valid (en delayed LAT advancing cycles)
//   flg    {invalid, inexact}
//   alt    en registered for one advancing cycle
module fconvi_mod #(
  parameter logic [15:0] BIAS_EXT = 16'h3fff,
  parameter int unsigned LAT      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        clkEn,
  input  logic [81:0] A,
  input  logic [1:0]  typ,
  input  logic        isS,
  output logic [64:0] res,
  output logic        rdy,
  output logic [1:0]  flg,
  output logic        alt
);

  localparam logic [1:0]  PTYPE_SNGL = 2'd0;
  localparam logic [1:0]  PTYPE_DBL  = 2'd1;
  localparam logic [1:0]  PTYPE_EXT  = 2'd2;

  localparam logic [64:0] RES_SMAX = {1'b0, 1'b0, {63{1'b1}}};
  localparam logic [64:0] RES_SMIN = {1'b1, 1'b1, 63'd0};
  localparam logic [64:0] RES_UMAX = {1'b0, {64{1'b1}}};
  localparam logic [63:0] M_TOP    = {1'b1, 63'd0};

  logic unused_a;
  assign unused_a = ^A[81:80];

  // Leading-zero count; only extended operands (explicit integer bit) can be unnormal.
  function automatic logic [5:0] lzc64(input logic [63:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) n = 6'(63 - i);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, classify, normalise
  // ---------------------------------------------------------------------------
  logic               sign_c, exp_zero, exp_ones, frac_nz, mant_nz, is_ext, typ_ok;
  logic [63:0]        m_raw, m_norm;
  logic signed [17:0] e_raw, e_norm;
  logic [5:0]         lz;
  logic               zero_c, den_c, inf_c, nan_c;
  logic               ge63_c, ge64_c, neg_c;
  logic [5:0]         sh_c;

  always_comb begin
    sign_c   = 1'b0;
    exp_zero = 1'b0;
    exp_ones = 1'b0;
    frac_nz  = 1'b0;
    mant_nz  = 1'b0;
    is_ext   = 1'b0;
    typ_ok   = 1'b1;
    m_raw    = 64'd0;
    e_raw    = 18'sd0;
    case (typ)
      PTYPE_SNGL: begin
        sign_c   = A[31];
        exp_zero = (A[30:23] == 8'd0);
        exp_ones = &A[30:23];
        frac_nz  = |A[22:0];
        mant_nz  = frac_nz;
        m_raw    = {1'b1, A[22:0], 40'd0};
        e_raw    = $signed({10'd0, A[30:23]} - 18'd127);
      end
      PTYPE_DBL: begin
        sign_c   = A[63];
        exp_zero = (A[62:52] == 11'd0);
        exp_ones = &A[62:52];
        frac_nz  = |A[51:0];
        mant_nz  = frac_nz;
        m_raw    = {1'b1, A[51:0], 11'd0};
        e_raw    = $signed({7'd0, A[62:52]} - 18'd1023);
      end
      PTYPE_EXT: begin
        is_ext   = 1'b1;
        sign_c   = A[79];
        exp_zero = (A[78:64] == 15'd0);
        exp_ones = &A[78:64];
        frac_nz  = |A[62:0];
        mant_nz  = |A[63:0];
        m_raw    = A[63:0];
        e_raw    = $signed({3'd0, A[78:64]} - {2'd0, BIAS_EXT});
      end
      default: typ_ok = 1'b0;
    endcase

    // Extended pseudo-zero (non-zero exponent, zero mantissa) is treated as zero.
    zero_c = !exp_ones && !mant_nz && (exp_zero || is_ext);
    den_c  = exp_zero && mant_nz;
    inf_c  = exp_ones && !frac_nz;
    nan_c  = exp_ones && frac_nz;

    lz     = lzc64(m_raw);
    m_norm = m_raw << lz;
    e_norm = e_raw - $signed({12'd0, lz});

    ge63_c = (e_norm >= 18'sd63);
    ge64_c = (e_norm >= 18'sd64);
    neg_c  = e_norm[17];
    // Right-shift count 63 - E, only meaningful for 0 <= E <= 62.
    sh_c   = (!neg_c && !ge63_c) ? ~e_norm[5:0] : 6'd0;
  end

  logic [LAT-1:0] vld_q;
  logic           alt_q;
  logic           s1_typ_ok, s1_sign, s1_iss, s1_zero, s1_den, s1_inf, s1_nan;
  logic           s1_ge63, s1_ge64, s1_neg;
  logic [63:0]    s1_m;
  logic [5:0]     s1_sh;

  // ---------------------------------------------------------------------------
  // Stage 2: coarse byte shift with sticky collection
  // ---------------------------------------------------------------------------
  logic [5:0]  coarse_amt;
  logic [63:0] m2_c;
  logic        sticky2_c;

  always_comb begin
    coarse_amt = {s1_sh[5:3], 3'b000};
    if (s1_neg) begin
      m2_c      = 64'd0;
      sticky2_c = |s1_m;
    end else begin
      m2_c      = s1_m >> coarse_amt;
      sticky2_c = |(s1_m & ((64'd1 << coarse_amt) - 64'd1));
    end
  end

  logic        s2_typ_ok, s2_sign, s2_iss, s2_zero, s2_den, s2_inf, s2_nan;
  logic        s2_ge63, s2_ge64, s2_neg, s2_sticky;
  logic [63:0] s2_m;
  logic [2:0]  s2_fine;

  // ---------------------------------------------------------------------------
  // Stage 3: fine shift, negate, saturate and special-case
  // ---------------------------------------------------------------------------
  logic [63:0] mag, mag_neg;
  logic        sticky3;
  logic [64:0] res_d;
  logic        inv_d, inx_d;

  always_comb begin
    mag     = s2_m >> s2_fine;
    sticky3 = s2_sticky | (|(s2_m & ((64'd1 << s2_fine) - 64'd1)));
    mag_neg = ~mag + 64'd1;
    res_d   = 65'd0;
    inv_d   = 1'b0;
    inx_d   = 1'b0;
    if (s2_typ_ok) begin
      if (s2_nan) begin
        res_d = s2_iss ? RES_SMIN : RES_UMAX;
        inv_d = 1'b1;
      end else if (s2_zero) begin
        res_d = 65'd0;
      end else if (s2_den) begin
        inx_d = 1'b1;
      end else if (s2_iss) begin
        if (s2_inf || s2_ge63) begin
          if (s2_sign) begin
            res_d = RES_SMIN;
            // -2^63 is the one representable value at E = 63.
            inv_d = s2_inf || s2_ge64 || (s2_m != M_TOP);
          end else begin
            res_d = RES_SMAX;
            inv_d = 1'b1;
          end
        end else begin
          res_d = s2_sign ? {mag_neg[63], mag_neg} : {1'b0, mag};
          inx_d = sticky3;
        end
      end else if (s2_sign) begin
        // Negative to unsigned: anything with magnitude >= 1 is out of range.
        if (s2_inf || !s2_neg) inv_d = 1'b1;
        else                   inx_d = sticky3;
      end else if (s2_inf || s2_ge64) begin
        res_d = RES_UMAX;
        inv_d = 1'b1;
      end else begin
        res_d = {1'b0, mag};
        inx_d = sticky3;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      alt_q     <= 1'b0;
      s1_typ_ok <= 1'b0;
      s1_sign   <= 1'b0;
      s1_iss    <= 1'b0;
      s1_zero   <= 1'b0;
      s1_den    <= 1'b0;
      s1_inf    <= 1'b0;
      s1_nan    <= 1'b0;
      s1_ge63   <= 1'b0;
      s1_ge64   <= 1'b0;
      s1_neg    <= 1'b0;
      s1_m      <= 64'd0;
      s1_sh     <= 6'd0;
      s2_typ_ok <= 1'b0;
      s2_sign   <= 1'b0;
      s2_iss    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_den    <= 1'b0;
      s2_inf    <= 1'b0;
      s2_nan    <= 1'b0;
      s2_ge63   <= 1'b0;
      s2_ge64   <= 1'b0;
      s2_neg    <= 1'b0;
      s2_sticky <= 1'b0;
      s2_m      <= 64'd0;
      s2_fine   <= 3'd0;
      res       <= 65'd0;
      flg       <= 2'b00;
    end else if (clkEn) begin
      vld_q     <= {vld_q[LAT-2:0], en};
      alt_q     <= en;
      s1_typ_ok <= typ_ok;
      s1_sign   <= sign_c;
      s1_iss    <= isS;
      s1_zero   <= zero_c;
      s1_den    <= den_c;
      s1_inf    <= inf_c;
      s1_nan    <= nan_c;
      s1_ge63   <= ge63_c;
      s1_ge64   <= ge64_c;
      s1_neg    <= neg_c;
      s1_m      <= m_norm;
      s1_sh     <= sh_c;
      s2_typ_ok <= s1_typ_ok;
      s2_sign   <= s1_sign;
      s2_iss    <= s1_iss;
      s2_zero   <= s1_zero;
      s2_den    <= s1_den;
      s2_inf    <= s1_inf;
      s2_nan    <= s1_nan;
      s2_ge63   <= s1_ge63;
      s2_ge64   <= s1_ge64;
      s2_neg    <= s1_neg;
      s2_sticky <= sticky2_c;
      s2_m      <= m2_c;
      s2_fine   <= s1_sh[2:0];
      res       <= res_d;
      flg       <= {inv_d, inv_d ? 1'b0 : inx_d};
    end
  end

  assign rdy = vld_q[LAT-1];
  assign alt = alt_q;

endmodule

// File: tb/tb_fconvi_mod.sv
// Directed-vector bench for fconvi_mod.
module tb_fconvi_mod;

  localparam logic [1:0] T_SNGL = 2'd0;
  localparam logic [1:0] T_DBL  = 2'd1;
  localparam logic [1:0] T_EXT  = 2'd2;
  localparam logic [1:0] T_BAD  = 2'd3;

  localparam logic [64:0] SMAX = 65'h0_7FFF_FFFF_FFFF_FFFF;
  localparam logic [64:0] SMIN = 65'h1_8000_0000_0000_0000;
  localparam logic [64:0] UMAX = 65'h0_FFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [1:0]  t;
    logic [81:0] a;
    logic        s;
    logic [64:0] r;
    logic [1:0]  f;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        clkEn = 1'b1;
  logic [81:0] A = '0;
  logic [1:0]  typ = 2'd0;
  logic        isS = 1'b0;
  logic [64:0] res;
  logic        rdy;
  logic [1:0]  flg;
  logic        alt;

  int checks = 0;
  int failures = 0;

  fconvi_mod #(
    .BIAS_EXT (16'h3fff),
    .LAT      (3)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .clkEn (clkEn),
    .A     (A),
    .typ   (typ),
    .isS   (isS),
    .res   (res),
    .rdy   (rdy),
    .flg   (flg),
    .alt   (alt)
  );

  always #5 clk = ~clk;

  task automatic idle(input int n);
    en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues one operand and returns outputs seen two and three cycles later.
  task automatic op(input logic [1:0] t, input logic [81:0] a, input logic s,
                    output logic early, output logic r, output logic [64:0] q,
                    output logic [1:0] f);
    typ = t;
    A   = a;
    isS = s;
    en  = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    @(posedge clk); #1;
    early = rdy;
    @(posedge clk); #1;
    r = rdy;
    q = res;
    f = flg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b expected 0", rdy); end
    checks++; if (res !== 65'd0) begin failures++; $display("FAIL reset_res: got %h expected 0", res); end
    checks++; if (flg !== 2'b00) begin failures++; $display("FAIL reset_flg: got %b expected 00", flg); end
    checks++; if (alt !== 1'b0) begin failures++; $display("FAIL reset_alt: got %b expected 0", alt); end
    rst = 1'b1;
    idle(2);
  endtask

  task automatic test_basic();
    logic e, r;
    logic [64:0] q;
    logic [1:0] f;
    op(T_DBL, 82'h400E_0000_0000_0000, 1'b1, e, r, q, f);
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL basic_early_rdy: got %b expected 0", e); end
    checks++; if (r !== 1'b1) begin failures++; $display("FAIL basic_rdy: got %b expected 1", r); end
    checks++; if (q !== 65'h3) begin failures++; $display("FAIL basic_res: got %h expected 3", q); end
    checks++; if (f !== 2'b01) begin failures++; $display("FAIL basic_flg: got %b expected 01", f); end
    @(posedge clk); #1;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL basic_single_rdy: got %b expected 0", rdy); end
  endtask

  task automatic test_truncate();
    vec_t v [6];
    logic e, r;
    logic [64:0] q;
    logic [1:0] f;
    v[0] = '{T_DBL,  82'h400E_0000_0000_0000, 1'b1, 65'h3, 2'b01};
    v[1] = '{T_DBL,  82'hC00E_0000_0000_0000, 1'b1, 65'h1_FFFF_FFFF_FFFF_FFFD, 2'b01};
    v[2] = '{T_SNGL, 82'h42C8_0000, 1'b1, 65'h64, 2'b00};
    v[3] = '{T_EXT,  82'({1'b0, 15'h3fff, 64'hC000_0000_0000_0000}), 1'b0, 65'h1, 2'b01};
    v[4] = '{T_SNGL, 82'hBF00_0000, 1'b0, 65'h0, 2'b01};
    v[5] = '{T_DBL,  82'h3FE0_0000_0000_0000, 1'b1, 65'h0, 2'b01};
    for (int i = 0; i < 6; i++) begin
      op(v[i].t, v[i].a, v[i].s, e, r, q, f);
      checks++; if (r !== 1'b1) begin failures++; $display("FAIL trunc[%0d]_rdy: got %b expected 1", i, r); end
      checks++; if (q !== v[i].r) begin failures++; $display("FAIL trunc[%0d]_res: got %h expected %h", i, q, v[i].r); end
      checks++; if (f !== v[i].f) begin failures++; $display("FAIL trunc[%0d]_flg: got %b expected %b", i, f, v[i].f); end
    end
  endtask

  task automatic test_specials();
    vec_t v [8];
    logic e, r;
    logic [64:0] q;
    logic [1:0] f;
    v[0] = '{T_SNGL, 82'h7FC0_0000, 1'b0, UMAX, 2'b10};
    v[1] = '{T_SNGL, 82'h7FC0_0000, 1'b1, SMIN, 2'b10};
    v[2] = '{T_DBL,  82'h8000_0000_0000_0000, 1'b1, 65'h0, 2'b00};
    v[3] = '{T_SNGL, 82'h0000_0001, 1'b0, 65'h0, 2'b01};
    v[4] = '{T_BAD,  82'h3FF0_0000_0000_0000, 1'b1, 65'h0, 2'b00};
    v[5] = '{T_DBL,  82'hFFF0_0000_0000_0000, 1'b1, SMIN, 2'b10};
    v[6] = '{T_DBL,  82'h7FF0_0000_0000_0000, 1'b0, UMAX, 2'b10};
    v[7] = '{T_DBL,  82'hFFF0_0000_0000_0000, 1'b0, 65'h0, 2'b10};
    for (int i = 0; i < 8; i++) begin
      op(v[i].t, v[i].a, v[i].s, e, r, q, f);
      checks++; if (r !== 1'b1) begin failures++; $display("FAIL spec[%0d]_rdy: got %b expected 1", i, r); end
      checks++; if (q !== v[i].r) begin failures++; $display("FAIL spec[%0d]_res: got %h expected %h", i, q, v[i].r); end
      checks++; if (f !== v[i].f) begin failures++; $display("FAIL spec[%0d]_flg: got %b expected %b", i, f, v[i].f); end
    end
  endtask

  task automatic test_saturation();
    vec_t v [9];
    logic e, r;
    logic [64:0] q;
    logic [1:0] f;
    v[0] = '{T_DBL, 82'hC3E0_0000_0000_0000, 1'b1, SMIN, 2'b00};
    v[1] = '{T_DBL, 82'hC3E0_0000_0000_0001, 1'b1, SMIN, 2'b10};
    v[2] = '{T_DBL, 82'h43E0_0000_0000_0000, 1'b1, SMAX, 2'b10};
    v[3] = '{T_DBL, 82'h43E0_0000_0000_0000, 1'b0, 65'h0_8000_0000_0000_0000, 2'b00};
    v[4] = '{T_DBL, 82'h43F0_0000_0000_0000, 1'b0, UMAX, 2'b10};
    v[5] = '{T_DBL, 82'hC008_0000_0000_0000, 1'b0, 65'h0, 2'b10};
    v[6] = '{T_EXT, 82'({1'b0, 15'h403e, 64'hFFFF_FFFF_FFFF_FFFF}), 1'b0, UMAX, 2'b00};
    v[7] = '{T_EXT, 82'({1'b0, 15'h403e, 64'hFFFF_FFFF_FFFF_FFFF}), 1'b1, SMAX, 2'b10};
    // Unnormal extended: 0.5 * 2^64 = 2^63.
    v[8] = '{T_EXT, 82'({1'b0, 15'h403f, 64'h4000_0000_0000_0000}), 1'b0,
             65'h0_8000_0000_0000_0000, 2'b00};
    for (int i = 0; i < 9; i++) begin
      op(v[i].t, v[i].a, v[i].s, e, r, q, f);
      checks++; if (r !== 1'b1) begin failures++; $display("FAIL sat[%0d]_rdy: got %b expected 1", i, r); end
      checks++; if (q !== v[i].r) begin failures++; $display("FAIL sat[%0d]_res: got %h expected %h", i, q, v[i].r); end
      checks++; if (f !== v[i].f) begin failures++; $display("FAIL sat[%0d]_flg: got %b expected %b", i, f, v[i].f); end
    end
  endtask

  task automatic test_alt();
    idle(3);
    typ = T_DBL; A = 82'h3FF0_0000_0000_0000; isS = 1'b1; en = 1'b1;
    @(posedge clk); #1;
    checks++; if (alt !== 1'b1) begin failures++; $display("FAIL alt_set: got %b expected 1", alt); end
    en = 1'b0; clkEn = 1'b0;
    @(posedge clk); #1;
    checks++; if (alt !== 1'b1) begin failures++; $display("FAIL alt_hold: got %b expected 1", alt); end
    clkEn = 1'b1;
    @(posedge clk); #1;
    checks++; if (alt !== 1'b0) begin failures++; $display("FAIL alt_clear: got %b expected 0", alt); end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [81:0] ops [3];
    logic        exp_r;
    int          rdy_count;
    ops[0] = 82'h3FF0_0000_0000_0000;
    ops[1] = 82'h4000_0000_0000_0000;
    ops[2] = 82'h4008_0000_0000_0000;
    typ = T_DBL; isS = 1'b1;
    rdy_count = 0;
    idle(4);
    for (int e = 1; e <= 10; e++) begin
      clkEn = !(e == 3 || e == 4);
      if (e <= 2) begin
        en = 1'b1; A = ops[e-1];
      end else if (e <= 5) begin
        en = 1'b1; A = ops[2];
      end else begin
        en = 1'b0;
      end
      @(posedge clk); #1;
      if (rdy === 1'b1) rdy_count++;
      exp_r = (e >= 5 && e <= 7);
      checks++;
      if (rdy !== exp_r) begin
        failures++; $display("FAIL b2b_rdy[edge %0d]: got %b expected %b", e, rdy, exp_r);
      end
      if (exp_r) begin
        checks++;
        if (res !== 65'(e - 4)) begin
          failures++; $display("FAIL b2b_res[edge %0d]: got %h expected %0d", e, res, e - 4);
        end
      end
    end
    clkEn = 1'b1;
    checks++;
    if (rdy_count != 3) begin
      failures++; $display("FAIL b2b_rdy_count: got %0d expected 3", rdy_count);
    end
  endtask

  task automatic test_reset_inflight();
    int          rdy_count;
    logic        e, r;
    logic [64:0] q;
    logic [1:0]  f;
    idle(4);
    typ = T_DBL; isS = 1'b1; en = 1'b1;
    A = 82'h400E_0000_0000_0000;
    @(posedge clk); #1;
    A = 82'h4000_0000_0000_0000;
    @(posedge clk); #1;
    A = 82'h3FF0_0000_0000_0000;
    @(posedge clk); #1;
    en = 1'b0;
    checks++; if (rdy !== 1'b1 || res !== 65'h3) begin
      failures++; $display("FAIL rst_pre: got rdy=%b res=%h expected rdy=1 res=3", rdy, res);
    end
    #1 rst = 1'b0;
    #1;
    checks++; if (rdy !== 1'b0) begin failures++; $display("FAIL rst_async_rdy: got %b expected 0", rdy); end
    checks++; if (res !== 65'd0) begin failures++; $display("FAIL rst_async_res: got %h expected 0", res); end
    checks++; if (flg !== 2'b00) begin failures++; $display("FAIL rst_async_flg: got %b expected 00", flg); end
    @(posedge clk); #1;
    rst = 1'b1;
    rdy_count = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) rdy_count++;
    end
    checks++; if (rdy_count != 0) begin
      failures++; $display("FAIL rst_dropped: got %0d rdy pulses expected 0", rdy_count);
    end
    op(T_DBL, 82'h4000_0000_0000_0000, 1'b0, e, r, q, f);
    checks++; if (r !== 1'b1 || q !== 65'h2 || f !== 2'b00) begin
      failures++; $display("FAIL rst_recover: got rdy=%b res=%h flg=%b expected 1/2/00", r, q, f);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncate();
    test_specials();
    test_saturation();
    test_alt();
    test_back_to_back();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
